// File: rtl/fp_operand_unpack.sv
// rtl/fp_operand_unpack.sv - unpack, classify and magnitude-order an IEEE754 single operand pair
// Optional NaN classification: define FP_UNPACK_NAN_EN.
module fp_operand_unpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        s_big,
  output logic        s_sml,
  output logic [7:0]  e_big,
  output logic [7:0]  e_sml,
  output logic [31:0] f_big,
  output logic [31:0] f_sml,
  output logic [7:0]  ediff,
  output logic        swapped,
  output logic        zero_big,
  output logic        zero_sml,
  output logic        inf_big,
  output logic        inf_sml,
  output logic        nan_big,
  output logic        nan_sml,
  input  logic        clr_sticky,
  output logic        sticky_exc
);

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [31:0] f;
    logic        zero;
    logic        inf;
    logic        nan;
  } opnd_t;

  // Denormals flush to an unsigned zero with e=0 so ediff stays exact.
  function automatic opnd_t unpack(input logic [31:0] x);
    opnd_t       o;
    logic [7:0]  ex;
    logic [22:0] m;
    ex = x[30:23];
    m  = x[22:0];
    o  = '0;
    if (ex == 8'd0) begin
      o.zero = 1'b1;
    end else if (ex == 8'hff) begin
      o.s = x[31];
      o.e = ex;
`ifdef FP_UNPACK_NAN_EN
      if (m != 23'd0) begin
        o.nan = 1'b1;
        o.f   = {9'h000, m};
      end else begin
        o.inf = 1'b1;
      end
`else
      o.inf = 1'b1;
`endif
    end else begin
      o.s = x[31];
      o.e = ex;
      o.f = {8'h00, 1'b1, m};
    end
    return o;
  endfunction

  logic        en;
  logic        v1;
  logic [31:0] a1;
  logic [31:0] b1;
  opnd_t       ua;
  opnd_t       ub;
  opnd_t       big;
  opnd_t       sml;
  logic        a_lt_b;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign ua     = unpack(a1);
  assign ub     = unpack(b1);
  // Ordering uses the raw magnitude fields; sign never participates.
  assign a_lt_b = a1[30:0] < b1[30:0];
  assign big    = a_lt_b ? ub : ua;
  assign sml    = a_lt_b ? ua : ub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
    end else if (en) begin
      v1 <= in_valid;
      a1 <= a;
      b1 <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s_big     <= 1'b0;
      s_sml     <= 1'b0;
      e_big     <= '0;
      e_sml     <= '0;
      f_big     <= '0;
      f_sml     <= '0;
      ediff     <= '0;
      swapped   <= 1'b0;
      zero_big  <= 1'b0;
      zero_sml  <= 1'b0;
      inf_big   <= 1'b0;
      inf_sml   <= 1'b0;
    end else if (en) begin
      out_valid <= v1;
      s_big     <= big.s;
      s_sml     <= sml.s;
      e_big     <= big.e;
      e_sml     <= sml.e;
      f_big     <= big.f;
      f_sml     <= sml.f;
      ediff     <= big.e - sml.e;
      swapped   <= a_lt_b;
      zero_big  <= big.zero;
      zero_sml  <= sml.zero;
      inf_big   <= big.inf;
      inf_sml   <= sml.inf;
    end
  end

`ifdef FP_UNPACK_NAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_big <= 1'b0;
      nan_sml <= 1'b0;
    end else if (en) begin
      nan_big <= big.nan;
      nan_sml <= sml.nan;
    end
  end
`else
  assign nan_big = 1'b0;
  assign nan_sml = 1'b0;
`endif

  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_exc <= 1'b0;
    end else if (out_valid && out_ready &&
                 (inf_big || inf_sml || nan_big || nan_sml)) begin
      sticky_exc <= 1'b1;
    end else if (clr_sticky) begin
      sticky_exc <= 1'b0;
    end
  end

endmodule

// File: doc/fp_operand_unpack.md
# fp_operand_unpack

Input-side counterpart to the adder's output exception stage. Accepts a pair of packed IEEE754 single-precision operands and unpacks each into sign, biased exponent and a 32-bit fraction with the hidden bit restored. It classifies zero, infinity and NaN, orders the operands by magnitude and computes the exponent difference for the alignment shifter. It is a 2-stage valid/ready pipeline that feeds the align/add datapath.

## Interface

Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- a, b  in  32 each  packed IEEE754 operands
- out_valid  out  1  unpacked result valid
- out_ready  in  1  downstream accepts
- s_big, s_sml  out  1 each  signs of larger/smaller-magnitude operand
- e_big, e_sml  out  8 each  biased exponents
- f_big, f_sml  out  32 each  fractions: {8'h00, hidden, mantissa[22:0]}
- ediff  out  8  e_big - e_sml, never negative
- swapped  out  1  1 when b had the larger magnitude
- zero_big, zero_sml, inf_big, inf_sml, nan_big, nan_sml  out  1 each  class flags
- clr_sticky  in  1  clears sticky_exc
- sticky_exc  out  1  sticky: an inf or NaN operand has left the block

## Operation

- Global stall enable: en = !out_valid | out_ready. in_ready = en.
- Stage 1 captures a, b and in_valid when en is high.
- Stage 2 classifies, orders and registers the result when en is high. out_valid is the stage-2 valid bit.
- Per-operand classification, where E = bits[30:23] and M = bits[22:0]:
  - E==0: zero. Denormals are flushed to zero. The sign is forced to 0, f=0 and e=0.
  - E==255: handled per Configuration.
  - Otherwise: f = {8'h00, 1'b1, M} and the sign is passed through.
- Ordering:
  - Compare {E,M} of a against b as unsigned values.
  - If a < b, then big=b, sml=a and swapped=1.
  - On ties, big=a and swapped=0.
  - The sign does not take part in the comparison.
- ediff = e_big - e_sml, using the post-classification exponents.
- sticky_exc:
  - Set on any output transfer (out_valid & out_ready) with any inf_* or nan_* flag high.
  - Cleared by clr_sticky.
  - If set and clear occur in the same cycle, set wins.

## Timing

- Latency: 2 cycles from an in_valid&in_ready edge to out_valid, when there is no stall.
- Throughput: 1 pair per cycle.
- Backpressure: while out_valid=1 and out_ready=0, both stages hold and in_ready=0. No pair is dropped or duplicated.
- out_valid is asserted when data is present. It and all data outputs stay stable until the transfer completes.
- While out_valid=0, bubbles collapse: the pipeline advances even if out_ready=0.
- Reset, asynchronous and valid at any time including mid-transfer:
  - Both stage-valid bits, out_valid and sticky_exc go to 0.
  - All data and flag outputs go to 0.
  - in_ready reads 1 as soon as rst_n is low.
  - In-flight pairs are discarded.

## Configuration

- Macro: FP_UNPACK_NAN_EN.
- Defined: when E==255 and M!=0, the operand is NaN. nan_*=1, inf_*=0 and f = {9'h000, M}. When E==255 and M==0, the operand is infinity, with f=0 and the sign passed through.
- Undefined: every E==255 operand is classified as infinity, with f=0 and the sign passed through. This matches the output stage, which never produces NaN. nan_* outputs are tied to 0.

## Test plan

- a=0x3F800000, b=0x40000000 → after 2 cycles:
  - big: s_big=0, e_big=128, f_big=0x00800000
  - sml: e_sml=127, f_sml=0x00800000
  - ediff=1, swapped=1
- a=0xC0400000, b=0x00000001 → zero_sml=1, e_sml=0, f_sml=0, s_sml=0, s_big=1, ediff=128, swapped=0.
- a=0x7FC00000, b=0x3F800000:
  - With the macro: nan_big=1, f_big=0x00400000.
  - Without the macro: inf_big=1, nan_big=0, f_big=0.
  - sticky_exc=1 in the cycle after the transfer. It stays 1 until clr_sticky. Asserting clr_sticky during a new inf transfer leaves it at 1.
- Stream 5 pairs with in_valid=1 and hold out_ready=0 for cycles 3–6:
  - in_ready drops once both stages are full.
  - All 5 results emerge in order, each exactly once.
- Assert rst_n=0 while 2 pairs are in flight → out_valid=0 immediately. After release, the first output comes from the first pair accepted post-reset.
- a=b=0x41200000 → swapped=0, ediff=0, and both outputs are identical.
